// File: rtl/axil_bch_regs.sv
// rtl/axil_bch_regs.sv - AXI4-Lite register block driving a BCH codec command/response port
// Software loads DATA_IN and MODE, pulses START, polls STATUS, then reads DATA_OUT/RSP_STAT.
module axil_bch_regs #(
  parameter int                ADDR_W   = 21,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h0BC4_0001
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]          s_axil_awprot,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  input  logic [DATA_W-1:0]   s_axil_wdata,
  input  logic [DATA_W/8-1:0] s_axil_wstrb,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  output logic [1:0]          s_axil_bresp,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  input  logic [ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]          s_axil_arprot,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic [DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]          s_axil_rresp,

  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_mode,
  output logic [DATA_W-1:0]   cmd_data,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_data,
  input  logic [7:0]          rsp_status
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_STATUS   = 3'd1;
  localparam logic [2:0] IDX_DATA_IN  = 3'd2;
  localparam logic [2:0] IDX_DATA_OUT = 3'd3;
  localparam logic [2:0] IDX_RSP_STAT = 3'd4;
  localparam logic [2:0] IDX_SCRATCH  = 3'd5;
  localparam logic [2:0] IDX_ID       = 3'd6;
  localparam logic [2:0] IDX_UNMAPPED = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic              ready_en;
  logic              aw_held;
  logic [2:0]        aw_idx_q;
  logic              w_held;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic              mode;
  logic              done;
  logic              overrun;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        rsp_stat;
  logic [DATA_W-1:0] scratch;
  logic [0:0]        state;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [2:0]        c_idx;
  logic [DATA_W-1:0] c_data;
  logic [STRB_W-1:0] c_strb;
  logic              start_req;
  logic              clr_done;
  logic              clr_overrun;
  logic              rsp_accept;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic              unused_bits;

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[ADDR_W-1:5], s_axil_awaddr[1:0],
                         s_axil_araddr[ADDR_W-1:5], s_axil_araddr[1:0]};

  // Readies depend only on flops so no AXI input reaches an AXI output combinationally.
  assign s_axil_awready = ready_en & ~aw_held & ~s_axil_bvalid;
  assign s_axil_wready  = ready_en & ~w_held & ~s_axil_bvalid;
  assign s_axil_arready = ready_en & ~s_axil_rvalid;
  assign cmd_data       = data_in;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // A beat arriving this cycle counts as a full holding register, giving 1 write per 2 cycles.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);
  assign c_idx  = aw_held ? aw_idx_q : s_axil_awaddr[4:2];
  assign c_data = w_held ? w_data_q : s_axil_wdata;
  assign c_strb = w_held ? w_strb_q : s_axil_wstrb;

  assign start_req   = commit & (c_idx == IDX_CTRL) & c_strb[0] & c_data[0];
  assign clr_done    = commit & (c_idx == IDX_STATUS) & c_strb[0] & c_data[1];
  assign clr_overrun = commit & (c_idx == IDX_STATUS) & c_strb[0] & c_data[2];
  assign rsp_accept  = rsp_valid & (state == ST_BUSY);

  function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] nxt,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[i*8 +: 8] = nxt[i*8 +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en      <= 1'b0;
      aw_held       <= 1'b0;
      aw_idx_q      <= '0;
      w_held        <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (commit) aw_held <= 1'b0;
      else if (aw_hs) aw_held <= 1'b1;
      if (aw_hs) aw_idx_q <= s_axil_awaddr[4:2];
      if (commit) w_held <= 1'b0;
      else if (w_hs) w_held <= 1'b1;
      if (w_hs) begin
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= (c_idx == IDX_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode    <= 1'b0;
      data_in <= '0;
      scratch <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (commit) begin
        case (c_idx)
          IDX_CTRL:    if (c_strb[0]) mode <= c_data[1];
          IDX_DATA_IN: data_in <= merge_strb(data_in, c_data, c_strb);
          IDX_SCRATCH: scratch <= merge_strb(scratch, c_data, c_strb);
          default:     ;
        endcase
      end
      // Status sticky bits: a new event in the same cycle beats the software clear.
      if (rsp_accept) done <= 1'b1;
      else if (clr_done) done <= 1'b0;
      if (start_req && state == ST_BUSY) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_mode  <= 1'b0;
      data_out  <= '0;
      rsp_stat  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state     <= ST_BUSY;
            cmd_valid <= 1'b1;
            cmd_mode  <= c_data[1];
          end
        end
        default: begin
          if (rsp_valid) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            data_out  <= rsp_data;
            rsp_stat  <= rsp_status;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axil_araddr[4:2])
      IDX_CTRL:     rd_data[1]   = mode;
      IDX_STATUS:   rd_data[2:0] = {overrun, done, state == ST_BUSY};
      IDX_DATA_IN:  rd_data      = data_in;
      IDX_DATA_OUT: rd_data      = data_out;
      IDX_RSP_STAT: rd_data[7:0] = rsp_stat;
      IDX_SCRATCH:  rd_data      = scratch;
      IDX_ID:       rd_data      = ID_VALUE;
      default:      rd_resp      = RESP_SLVERR;
    endcase
  end

  // Read data is sampled from the pre-edge registers, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data;
      s_axil_rresp  <= rd_resp;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_bch_regs.sv
// tb/tb_axil_bch_regs.sv - scoreboard bench for axil_bch_regs
// Directed stimulus pushes expected B/R responses; a negedge monitor pops and compares them.
module tb_axil_bch_regs;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        s_axil_awvalid, s_axil_awready;
  logic [20:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_arvalid, s_axil_arready;
  logic [20:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_rvalid, s_axil_rready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        cmd_valid, cmd_ready, cmd_mode;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_status;

  axil_bch_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status)
  );

  typedef struct { string name; logic [1:0] resp; } bexp_t;
  typedef struct { string name; logic [31:0] data; logic [1:0] resp; } rexp_t;
  bexp_t b_q[$];
  rexp_t r_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bexp_t eb;
    rexp_t er;
    if (rst_n && s_axil_bvalid && s_axil_bready) begin
      chk("b_expected", 32'(b_q.size() != 0), 32'd1);
      if (b_q.size() != 0) begin
        eb = b_q.pop_front();
        chk({eb.name, "_bresp"}, 32'(s_axil_bresp), 32'(eb.resp));
      end
    end
    if (rst_n && s_axil_rvalid && s_axil_rready) begin
      chk("r_expected", 32'(r_q.size() != 0), 32'd1);
      if (r_q.size() != 0) begin
        er = r_q.pop_front();
        chk({er.name, "_rdata"}, s_axil_rdata, er.data);
        chk({er.name, "_rresp"}, 32'(s_axil_rresp), 32'(er.resp));
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_b(input string name, input logic [1:0] resp);
    bexp_t e;
    e.name = name;
    e.resp = resp;
    b_q.push_back(e);
  endtask

  task automatic wait_b(input string name);
    int   n   = 0;
    logic got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = s_axil_bvalid && s_axil_bready;
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_b_arrived"}, 32'(got), 32'd1);
  endtask

  task automatic wait_r(input string name);
    int   n   = 0;
    logic got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = s_axil_rvalid && s_axil_rready;
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_r_arrived"}, 32'(got), 32'd1);
  endtask

  task automatic axi_write(input string name, input logic [20:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    int   n = 0;
    logic aw_hit, w_hit;
    push_b(name, er);
    s_axil_awaddr  = a;
    s_axil_wdata   = d;
    s_axil_wstrb   = s;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
      @(negedge clk);
      aw_hit = s_axil_awvalid && s_axil_awready;
      w_hit  = s_axil_wvalid && s_axil_wready;
      @(posedge clk);
      #1;
      if (aw_hit) s_axil_awvalid = 1'b0;
      if (w_hit)  s_axil_wvalid  = 1'b0;
      n++;
    end
    chk({name, "_accept"}, 32'(s_axil_awvalid || s_axil_wvalid), 32'd0);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    wait_b(name);
  endtask

  task automatic axi_read(input string name, input logic [20:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
    int    n = 0;
    logic  hit;
    rexp_t e;
    e.name = name;
    e.data = ed;
    e.resp = er;
    r_q.push_back(e);
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    while (s_axil_arvalid && n < 50) begin
      @(negedge clk);
      hit = s_axil_arvalid && s_axil_arready;
      @(posedge clk);
      #1;
      if (hit) s_axil_arvalid = 1'b0;
      n++;
    end
    chk({name, "_ar_accept"}, 32'(s_axil_arvalid), 32'd0);
    s_axil_arvalid = 1'b0;
    wait_r(name);
  endtask

  task automatic ack_cmd();
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic codec_rsp(input logic [31:0] d, input logic [7:0] st);
    rsp_valid  = 1'b1;
    rsp_data   = d;
    rsp_status = st;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    s_axil_awvalid = 1'b0; s_axil_awaddr = '0; s_axil_awprot = '0;
    s_axil_wvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_bready = 1'b1;
    s_axil_arvalid = 1'b0; s_axil_araddr = '0; s_axil_arprot = '0;
    s_axil_rready = 1'b1;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_status = '0;

    // reset and ready release
    cycles(3);
    chk("reset_ctrl_outs", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                               s_axil_rvalid, cmd_valid, cmd_mode, s_axil_bresp, s_axil_rresp}), 32'd0);
    chk("reset_rdata", s_axil_rdata, 32'd0);
    chk("reset_cmd_data", cmd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd7);
    axi_read("id", 21'h18, 32'h0BC4_0001, 2'b00);

    // SCRATCH: W three cycles ahead of AW, strobed, with back-pressured B
    push_b("scratch_strb", 2'b00);
    s_axil_bready = 1'b0;
    s_axil_wdata = 32'hDEAD_BEEF;
    s_axil_wstrb = 4'b0101;
    s_axil_wvalid = 1'b1;
    @(negedge clk);
    chk("w_early_ready", 32'(s_axil_wready), 32'd1);
    @(posedge clk);
    #1;
    s_axil_wvalid = 1'b0;
    cycles(2);
    s_axil_awaddr = 21'h14;
    s_axil_awvalid = 1'b1;
    @(negedge clk);
    chk("aw_late_ready", 32'(s_axil_awready), 32'd1);
    @(posedge clk);
    #1;
    s_axil_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_held", 32'(s_axil_bvalid), 32'd1);
      @(posedge clk);
      #1;
    end
    s_axil_bready = 1'b1;
    wait_b("scratch_strb");
    @(negedge clk);
    chk("b_single", 32'(s_axil_bvalid), 32'd0);
    @(posedge clk);
    #1;
    axi_read("scratch_rb", 21'h14, 32'h00AD_00EF, 2'b00);

    // unmapped offset
    axi_write("unmapped_w", 21'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10);
    axi_read("unmapped_r", 21'h1C, 32'h0, 2'b10);
    axi_read("scratch_kept", 21'h14, 32'h00AD_00EF, 2'b00);

    // same-cycle read and write of SCRATCH: read sees the old value
    fork
      axi_write("rw_same_w", 21'h14, 32'h1234_5678, 4'hF, 2'b00);
      axi_read("rw_same_r", 21'h14, 32'h00AD_00EF, 2'b00);
    join
    axi_read("rw_after", 21'h14, 32'h1234_5678, 2'b00);

    // encode
    axi_write("data_in", 21'h08, 32'h0000_1234, 4'hF, 2'b00);
    axi_write("start_enc", 21'h00, 32'h1, 4'hF, 2'b00);
    chk("enc_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("enc_cmd_mode", 32'(cmd_mode), 32'd0);
    chk("enc_cmd_data", cmd_data, 32'h0000_1234);
    axi_read("enc_busy", 21'h04, 32'h1, 2'b00);
    chk("enc_cmd_held", 32'(cmd_valid), 32'd1);
    ack_cmd();
    chk("enc_cmd_dropped", 32'(cmd_valid), 32'd0);
    codec_rsp(32'h00AB_1234, 8'h00);
    axi_read("enc_status", 21'h04, 32'h2, 2'b00);
    axi_read("enc_data_out", 21'h0C, 32'h00AB_1234, 2'b00);
    axi_read("enc_rsp_stat", 21'h10, 32'h0, 2'b00);
    axi_write("clr_done", 21'h04, 32'h2, 4'hF, 2'b00);
    axi_read("done_cleared", 21'h04, 32'h0, 2'b00);

    // decode, then START while busy
    axi_write("start_dec", 21'h00, 32'h3, 4'hF, 2'b00);
    chk("dec_cmd_mode", 32'(cmd_mode), 32'd1);
    axi_read("ctrl_mode", 21'h00, 32'h2, 2'b00);
    ack_cmd();
    axi_write("start_busy", 21'h00, 32'h1, 4'hF, 2'b00);
    axi_read("overrun_set", 21'h04, 32'h5, 2'b00);
    axi_read("ctrl_mode0", 21'h00, 32'h0, 2'b00);
    axi_write("clr_overrun", 21'h04, 32'h4, 4'hF, 2'b00);
    axi_read("overrun_clr", 21'h04, 32'h1, 2'b00);
    chk("no_reissue", 32'(cmd_valid), 32'd0);

    // codec response in the same cycle as a DONE clear commit
    push_b("w1c_race", 2'b00);
    s_axil_awaddr = 21'h04; s_axil_wdata = 32'h2; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    rsp_valid = 1'b1; rsp_data = 32'hCAFE_0001; rsp_status = 8'h03;
    @(negedge clk);
    chk("race_aligned", 32'({s_axil_awready, s_axil_wready}), 32'd3);
    @(posedge clk);
    #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; rsp_valid = 1'b0;
    wait_b("w1c_race");
    axi_read("race_status", 21'h04, 32'h2, 2'b00);
    axi_read("race_data_out", 21'h0C, 32'hCAFE_0001, 2'b00);
    axi_read("race_rsp_stat", 21'h10, 32'h3, 2'b00);

    // reset with a pending command
    axi_write("start_rst", 21'h00, 32'h1, 4'hF, 2'b00);
    chk("rst_cmd_pending", 32'(cmd_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_drop", 32'({cmd_valid, s_axil_awready, s_axil_bvalid, s_axil_rvalid}), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    codec_rsp(32'h5555_AAAA, 8'h7F);
    axi_read("rst_status", 21'h04, 32'h0, 2'b00);
    axi_read("rst_data_out", 21'h0C, 32'h0, 2'b00);
    axi_read("rst_scratch", 21'h14, 32'h0, 2'b00);

    cycles(2);
    chk("sb_drained", 32'(b_q.size() + r_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
